// File: rtl/tdm_demux4.sv
// tdm_demux4 -- registered 1:4 TDM demultiplexer (receive end of a 4-lane link).
// Locks to the start-of-frame marker and steers each sample to its lane register.
//
// Ports
//   clk, rst_n          single rising-edge clock, synchronous active-low reset
//   in_data[W]          serial TDM sample
//   in_valid            sample valid this cycle (no backpressure)
//   in_sof              with in_valid, marks the lane-0 sample
//   Y[4*W]              lane registers, lane k = Y[k*W +: W]
//   lane_valid[4]       lane write pulse (all ones on frame load in latch mode)
//   frame_done          pulse: lane-3 sample of a locked frame accepted
//   locked              high while in LOCK
//   sync_err            pulse: in_sof at a non-zero slot while in LOCK
//
// Build option: define TDM_FRAME_LATCH_EN to collect samples in a shadow buffer
// and load Y as a whole frame only when frame_done fires.

module tdm_lane_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module tdm_demux4 #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  input  logic           in_sof,
  output logic [4*W-1:0] Y,
  output logic [3:0]     lane_valid,
  output logic           frame_done,
  output logic           locked,
  output logic           sync_err
);
  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [1:0]      slot_q, slot_d;
  logic [3:0]      wr;       // one-hot lane write this cycle
  logic [3:0]      lv_d;
  logic            fdone_d, serr_d;
  logic [3:0][W-1:0] lane_q;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    wr      = 4'b0000;
    fdone_d = 1'b0;
    serr_d  = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: if (in_sof) begin
          wr      = 4'b0001;
          state_d = LOCK;
          slot_d  = 2'd1;
        end
        LOCK: if (in_sof) begin
          // A marker mid-frame abandons the partial frame and restarts at lane 0.
          wr      = 4'b0001;
          serr_d  = (slot_q != 2'd0);
          slot_d  = 2'd1;
        end else begin
          wr      = 4'b0001 << slot_q;
          fdone_d = (slot_q == 2'd3);
          slot_d  = slot_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      slot_q     <= 2'd0;
      lane_valid <= 4'b0000;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      lane_valid <= lv_d;
      frame_done <= fdone_d;
      sync_err   <= serr_d;
    end
  end

  assign locked = (state_q == LOCK);
  assign Y      = lane_q;

`ifdef TDM_FRAME_LATCH_EN
  // A lane-3 write only happens on the last sample of a locked frame, so wr[3]
  // doubles as the whole-frame load strobe.
  logic [2:0][W-1:0] shadow_q;
  assign lv_d = {4{wr[3]}};

  for (genvar k = 0; k < 4; k++) begin : g_lane
    if (k < 3) begin : g_buf
      tdm_lane_reg #(.W(W)) u_shadow (
        .clk(clk), .rst_n(rst_n), .we(wr[k]), .d(in_data), .q(shadow_q[k])
      );
      tdm_lane_reg #(.W(W)) u_out (
        .clk(clk), .rst_n(rst_n), .we(wr[3]), .d(shadow_q[k]), .q(lane_q[k])
      );
    end else begin : g_last
      tdm_lane_reg #(.W(W)) u_out (
        .clk(clk), .rst_n(rst_n), .we(wr[3]), .d(in_data), .q(lane_q[k])
      );
    end
  end
`else
  assign lv_d = wr;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    tdm_lane_reg #(.W(W)) u_out (
      .clk(clk), .rst_n(rst_n), .we(wr[k]), .d(in_data), .q(lane_q[k])
    );
  end
`endif

endmodule
